// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, round count, state encoding and the
// GF(2^8) helpers used to build the S-box.
package aes_pkg;

  localparam int         AES_KEY_W         = 128;
  localparam int         AES128_ROUNDS     = 10;
  localparam logic [7:0] RCON_INIT_DEFAULT = 8'h01;

  typedef logic [AES_KEY_W-1:0] key_t;

  typedef enum logic {
    IDLE,
    EXPAND
  } keyexp_state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, zero maps to zero) plus affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_scheduling.sv
// Combinational AES-128 round-key stage: one round key and the next rcon
// from the current round key and rcon. Byte 0 of each word sits in the low bits.
module aes_key_scheduling
  import aes_pkg::*;
(
  input  key_t       key_in,
  input  logic [7:0] key_rcon_in,
  output key_t       key_next_out,
  output logic [7:0] key_rcon_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[31:0];
  assign w1 = key_in[63:32];
  assign w2 = key_in[95:64];
  assign w3 = key_in[127:96];

  // RotWord moves byte 1 into the byte-0 slot; rcon lands on byte 0.
  assign rot  = {w3[7:0], w3[31:24], w3[23:16], w3[15:8]};
  assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]),
                 sbox(rot[7:0]) ^ key_rcon_in};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next_out = {n3, n2, n1, n0};
  assign key_rcon_out = {key_rcon_in[6:0], 1'b0} ^ (key_rcon_in[7] ? 8'h1b : 8'h00);

endmodule

// File: rtl/aes_key_expansion.sv
// Sequential AES-128 key expansion: one round per clock into a local round-key
// register file, served through a combinational random-access read port.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int         NUM_ROUNDS = AES128_ROUNDS,
  parameter logic [7:0] RCON_INIT  = RCON_INIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
);

  if (NUM_ROUNDS != AES128_ROUNDS) begin : g_rounds_check
    $error("aes_key_expansion supports only NUM_ROUNDS=10");
  end

  // Handshake: a key transfers on a rising edge where key_valid && key_ready;
  // key_ready is high exactly in IDLE and the key is never buffered.
  keyexp_state_t state;
  keyexp_state_t state_next;

  key_t       rk [0:NUM_ROUNDS];
  key_t       cur_key;
  key_t       next_key;
  logic [7:0] rcon;
  logic [7:0] rcon_next;
  logic [3:0] round_cnt;
  logic       last_round;

  assign last_round = (round_cnt == 4'(NUM_ROUNDS));

  aes_key_scheduling u_sched (
    .key_in       (cur_key),
    .key_rcon_in  (rcon),
    .key_next_out (next_key),
    .key_rcon_out (rcon_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_next = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (last_round) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_key    <= '0;
      rcon       <= '0;
      round_cnt  <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            rk[0]      <= key_in;
            cur_key    <= key_in;
            rcon       <= RCON_INIT;
            round_cnt  <= 4'd1;
            keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          rk[round_cnt] <= next_key;
          cur_key       <= next_key;
          rcon          <= rcon_next;
          round_cnt     <= round_cnt + 4'd1;
          if (last_round) begin
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rk_rd_data = '0;
    if (rk_rd_idx <= 4'(NUM_ROUNDS)) rk_rd_data = rk[rk_rd_idx];
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: byte-level FIPS-197 reference model with a
// table S-box, scenario tasks and a scoreboard queue for read-port sweeps.
module tb_aes_key_expansion;

  localparam logic [2047:0] SBOX_TBL = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;

  localparam logic [127:0] FIPS_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] FIPS_RK1  = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] FIPS_RK10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] ZERO_RK10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;

  logic [127:0] exp_rk [11];
  logic [7:0]   exp_rcon [10];
  logic [127:0] exp_q [$];
  int           n_checks;
  int           n_fail;

  aes_key_expansion dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [2047:0] tbl;
    int idx;
    tbl = SBOX_TBL;
    idx = int'(x);
    return tbl[2047 - 8*idx -: 8];
  endfunction

  // Reference: FIPS-197 word recurrence over a 44x4 byte array.
  task automatic model_expand(input logic [127:0] key);
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    int rc;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) w[i][b] = key[32*i + 8*b +: 8];
    rc = 1;
    for (int i = 4; i < 44; i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
      if (i % 4 == 0) begin
        exp_rcon[i/4 - 1] = 8'(rc);
        t[0] = tb_sbox(w[i-1][1]) ^ 8'(rc);
        t[1] = tb_sbox(w[i-1][2]);
        t[2] = tb_sbox(w[i-1][3]);
        t[3] = tb_sbox(w[i-1][0]);
        rc = rc * 2;
        if (rc > 255) rc = (rc - 256) ^ 'h1b;
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t[b];
    end
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int b = 0; b < 4; b++) exp_rk[r][32*c + 8*b +: 8] = w[4*r + c][b];
  endtask

  task automatic accept_key(input logic [127:0] k);
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Called one negedge after acceptance; returns cycles to done or -1.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, keys_valid, key_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0001", {busy, done, keys_valid, key_ready});
    end
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = 4'(i);
      #1;
      n_checks++;
      if (rk_rd_data !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_rk[%0d] got %h want 0", i, rk_rd_data);
      end
    end
  endtask

  task automatic test_fips();
    int cyc;
    model_expand(FIPS_KEY);
    n_checks++;
    if (exp_rk[1] !== FIPS_RK1 || exp_rk[10] !== FIPS_RK10) begin
      n_fail++;
      $display("FAIL model_fips got %h / %h want %h / %h", exp_rk[1], exp_rk[10], FIPS_RK1, FIPS_RK10);
    end
    accept_key(FIPS_KEY);
    n_checks++;
    if ({busy, key_ready, keys_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL fips_busy got %b want 100", {busy, key_ready, keys_valid});
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 11) begin
      n_fail++;
      $display("FAIL fips_latency got %0d want 11", cyc);
    end
    n_checks++;
    if ({keys_valid, busy, key_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL fips_done_flags got %b want 101", {keys_valid, busy, key_ready});
    end
    rk_rd_idx = 4'd0; #1;
    n_checks++;
    if (rk_rd_data !== FIPS_KEY) begin
      n_fail++;
      $display("FAIL fips_rk0 got %h want %h", rk_rd_data, FIPS_KEY);
    end
    rk_rd_idx = 4'd1; #1;
    n_checks++;
    if (rk_rd_data !== FIPS_RK1) begin
      n_fail++;
      $display("FAIL fips_rk1 got %h want %h", rk_rd_data, FIPS_RK1);
    end
    rk_rd_idx = 4'd10; #1;
    n_checks++;
    if (rk_rd_data !== FIPS_RK10) begin
      n_fail++;
      $display("FAIL fips_rk10 got %h want %h", rk_rd_data, FIPS_RK10);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || keys_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fips_done_pulse got done=%b kv=%b want 0 1", done, keys_valid);
    end
  endtask

  task automatic test_zero_key_rcon();
    model_expand(128'h0);
    accept_key(128'h0);
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (dut.rcon !== exp_rcon[k-1]) begin
        n_fail++;
        $display("FAIL rcon_round%0d got %h want %h", k, dut.rcon, exp_rcon[k-1]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done got %b want 1", done);
    end
    rk_rd_idx = 4'd10; #1;
    n_checks++;
    if (rk_rd_data !== ZERO_RK10 || exp_rk[10] !== ZERO_RK10) begin
      n_fail++;
      $display("FAIL zero_rk10 got %h model %h want %h", rk_rd_data, exp_rk[10], ZERO_RK10);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int saw_done;
    accept_key(FIPS_KEY);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || keys_valid || busy) saw_done++;
    end
    n_checks++;
    if (saw_done !== 0) begin
      n_fail++;
      $display("FAIL abort_flags got %0d active cycles want 0", saw_done);
    end
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = 4'(i);
      #1;
      n_checks++;
      if (rk_rd_data !== 128'h0) begin
        n_fail++;
        $display("FAIL abort_rk[%0d] got %h want 0", i, rk_rd_data);
      end
    end
    accept_key(FIPS_KEY);
    wait_done(cyc);
    rk_rd_idx = 4'd10; #1;
    n_checks++;
    if (cyc !== 11 || rk_rd_data !== FIPS_RK10) begin
      n_fail++;
      $display("FAIL abort_rerun got lat=%0d rk10=%h want 11 %h", cyc, rk_rd_data, FIPS_RK10);
    end
  endtask

  // Key B is held valid throughout A's expansion and must land afterwards.
  task automatic test_ignore_during_expand();
    logic [127:0] ka, kb, a10;
    int cyc;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model_expand(ka);
    a10 = exp_rk[10];
    @(negedge clk);
    key_in = ka;
    key_valid = 1'b1;
    @(negedge clk);
    key_in = kb;
    n_checks++;
    if (key_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ready got %b want 0", key_ready);
    end
    wait_done(cyc);
    rk_rd_idx = 4'd10; #1;
    n_checks++;
    if (cyc !== 11 || rk_rd_data !== a10 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first got lat=%0d rk10=%h rdy=%b want 11 %h 1", cyc, rk_rd_data, key_ready, a10);
    end
    @(negedge clk);
    key_valid = 1'b0;
    n_checks++;
    if (keys_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_second_accept got kv=%b busy=%b want 0 1", keys_valid, busy);
    end
    model_expand(kb);
    wait_done(cyc);
    rk_rd_idx = 4'd10; #1;
    n_checks++;
    if (cyc !== 11 || rk_rd_data !== exp_rk[10]) begin
      n_fail++;
      $display("FAIL hold_second got lat=%0d rk10=%h want 11 %h", cyc, rk_rd_data, exp_rk[10]);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] kb;
    int cyc;
    accept_key({$urandom, $urandom, $urandom, $urandom});
    wait_done(cyc);
    kb = {$urandom, $urandom, $urandom, $urandom};
    model_expand(kb);
    key_in = kb;
    key_valid = 1'b1;
    n_checks++;
    if (keys_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_valid got %b want 1", keys_valid);
    end
    @(negedge clk);
    key_valid = 1'b0;
    n_checks++;
    if (keys_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_valid_drop got %b want 0", keys_valid);
    end
    rk_rd_idx = 4'd0; #1;
    n_checks++;
    if (rk_rd_data !== kb) begin
      n_fail++;
      $display("FAIL b2b_rk0 got %h want %h", rk_rd_data, kb);
    end
    wait_done(cyc);
    rk_rd_idx = 4'd10; #1;
    n_checks++;
    if (cyc !== 11 || keys_valid !== 1'b1 || rk_rd_data !== exp_rk[10]) begin
      n_fail++;
      $display("FAIL b2b_second got lat=%0d kv=%b rk10=%h want 11 1 %h", cyc, keys_valid, rk_rd_data, exp_rk[10]);
    end
  endtask

  // Sweeps the whole index range against the last modelled schedule.
  task automatic test_read_sweep(input string tag);
    logic [127:0] exp_v;
    for (int i = 0; i < 11; i++) exp_q.push_back(exp_rk[i]);
    for (int i = 11; i < 16; i++) exp_q.push_back(128'h0);
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = 4'(i);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rk_rd_data !== exp_v) begin
        n_fail++;
        $display("FAIL %s_rk[%0d] got %h want %h", tag, i, rk_rd_data, exp_v);
      end
    end
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    int cyc;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      model_expand(k);
      accept_key(k);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 11) begin
        n_fail++;
        $display("FAIL rand%0d_latency got %0d want 11", n, cyc);
      end
      test_read_sweep($sformatf("rand%0d", n));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_rd_idx = '0;
    test_reset();
    test_fips();
    test_read_sweep("fips");
    test_zero_key_rcon();
    test_reset_mid();
    test_ignore_during_expand();
    test_back_to_back();
    test_read_sweep("b2b");
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Sequential AES-128 key-expansion engine. Accepts a cipher key over a valid/ready handshake.
- Iterates the existing combinational round-key stage (aes_key_scheduling) once per clock.
- Stores all NUM_ROUNDS+1 round keys in an internal register file.
- Serves round keys to the downstream round datapath through a random-access read port.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds. Only 10 is supported (AES-128); elaboration fails otherwise.
- RCON_INIT, 8'h01, round constant applied in round 1.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- key_valid  input  1  key_in is valid
- key_ready  output  1  block can accept a key (high only in IDLE)
- key_in  input  128  cipher key; byte k at bits [8k+7:8k], 32-bit word w at bits [32w+31:32w]
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse: all round keys written
- keys_valid  output  1  register file holds a complete, consistent schedule
- rk_rd_idx  input  4  round-key index to read (0..NUM_ROUNDS)
- rk_rd_data  output  128  round key rk[rk_rd_idx], same byte order as key_in

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE.
  - busy=0, done=0, keys_valid=0, key_ready=1 after reset deasserts.
  - All rk[] entries, cur_key, rcon and round_cnt clear to 0; rk_rd_data reads 0.
  - Reset mid-expansion aborts the expansion; no partial keys_valid.
- FSM states: IDLE, EXPAND.
- IDLE:
  - key_ready=1.
  - On an edge with key_valid=1: rk[0]<=key_in, cur_key<=key_in, rcon<=RCON_INIT, round_cnt<=1, keys_valid<=0, go EXPAND.
  - key_valid=0: hold.
- EXPAND:
  - key_ready=0, busy=1. key_valid is ignored; the key is not buffered.
  - Each edge: rk[round_cnt]<=next_key, cur_key<=next_key, rcon<=rcon_next, round_cnt<=round_cnt+1.
  - next_key and rcon_next come from the sub-module driven by cur_key and rcon.
  - When round_cnt==NUM_ROUNDS, the same edge instead does: go IDLE, done<=1, keys_valid<=1.
- Latency:
  - Accept edge E0; rk[1..10] are written at edges E1..E10.
  - done is high for exactly the cycle after E10 and clears at E11.
  - Total 11 cycles from acceptance to usable schedule.
- rcon sequence across rounds: 01,02,04,08,10,20,40,80,1b,36.
  - rcon register width is 8 bits; the 0x80 to 0x1b reduction is done by the sub-module.
- Read port:
  - Combinational: rk_rd_data = rk[rk_rd_idx] when rk_rd_idx<=NUM_ROUNDS, else 128'h0.
  - Reading during EXPAND returns whatever is currently stored. Consumers must gate reads on keys_valid.
- New key while keys_valid=1:
  - Accepted normally.
  - keys_valid drops at the acceptance edge.
  - rk[0] is overwritten at that same edge.
- rst has priority over every other event, including an acceptance or the final round edge.

Decomposition:
- Shared package aes_pkg holds:
  - AES_KEY_W=128, AES128_ROUNDS=10, RCON_INIT_DEFAULT=8'h01.
  - typedef key_t (logic [127:0]).
  - enum keyexp_state_t {IDLE, EXPAND}.
- One sub-module: aes_key_scheduling, instantiated once.
  - Ports: key_in=cur_key, key_rcon_in=rcon, key_next_out=next_key, key_rcon_out=rcon_next.
  - No other sub-modules. The register file is a local array.

Test Plan:
- FIPS-197 key: key_in=128'h3c4fcf098815f7aba6d2ae2816157e2b, one-cycle key_valid.
  - done exactly 11 cycles after acceptance.
  - rk[1]=128'h05766c2a3939a323b12c548817fefaa0.
  - rk[10]=128'ha60c63b6c80c3fe18925eec9a8f914d0.
  - rk[0]=key_in.
- All-zero key: rk[10]=128'h8e188f6fcf51e92311e2923ecb5befb4.
  - The internal rcon trace, probed per round, matches 01..36.
- Reset at cycle 5 of expansion:
  - keys_valid=0, done never pulses, busy=0, rk_rd_data=0 for all idx.
  - A following FIPS key then expands correctly.
- key_valid held high with a different key during EXPAND:
  - key_ready=0; that key is ignored.
  - Result equals the first key's schedule; the second key is accepted on the first IDLE cycle.
- Back-to-back keys:
  - keys_valid falls on the second acceptance edge, rises with the second done.
  - rk[10] matches the second key.
- Read port sweep after done, rk_rd_idx=0..15:
  - idx 0..10 return the expected keys.
  - idx 11..15 return 128'h0.
